// File: rtl/fetch_sequencer_pkg.sv
// Constants and types shared by the fetch sequencer, instruction memory and decode.
// The state encoding is fixed so other blocks can decode it.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  localparam int unsigned OPCODE_W  = 6;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam logic [31:0] INIT_ADDR = 32'hFFFF_FFFC;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [OPCODE_W-1:0] funcode_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner: addresses the combinational instruction memory and registers
// the returned word for decode, with stall, redirect, halt-marker and fault handling.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned SIZE_IM  = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_addr,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [5:0]       if_ctr,
  output logic [5:0]       if_funcode,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * SIZE_IM);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         if_valid_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;
  logic         halted_q;
  logic         fault_q;

  logic pc_out_of_range;
  logic is_halt_word;
  logic deliver;
  logic restart;

  assign pc_out_of_range = (pc_q >= PC_LIMIT);
  assign is_halt_word    = (opcode_of(imem_instr) == HALT_OP);

  // Redirect beats the range fault, which beats stall, which beats halt detection.
  assign deliver = (state_q == S_FETCH) && !redirect_valid && !pc_out_of_range
                   && !stall && !is_halt_word;
  assign restart = start && (state_q != S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= INIT_ADDR;
      if_valid_q <= 1'b0;
      if_instr_q <= HALT_WORD;
      if_pc_q    <= INIT_ADDR;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
          end
        end

        S_FETCH: begin
          if (redirect_valid) begin
            pc_q       <= redirect_addr;
            if_valid_q <= 1'b0;
            if (redirect_addr[1:0] != 2'b00) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
              fault_q  <= 1'b1;
            end
          end else if (pc_out_of_range) begin
            state_q    <= S_HALT;
            halted_q   <= 1'b1;
            fault_q    <= 1'b1;
            if_valid_q <= 1'b0;
          end else if (!stall) begin
            if_instr_q <= imem_instr;
            if_pc_q    <= pc_q;
            if (is_halt_word) begin
              if_valid_q <= 1'b0;
              state_q    <= S_HALT;
              halted_q   <= 1'b1;
            end else begin
              if_valid_q <= 1'b1;
              pc_q       <= pc_q + 32'd4;
            end
          end
        end

        S_HALT: begin
          if (start) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            if_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_fetch_count (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (restart),
    .en_i   (deliver),
    .count_o(fetch_count)
  );

  assign imem_addr  = pc_q;
  assign if_valid   = if_valid_q;
  assign if_instr   = if_instr_q;
  assign if_pc      = if_pc_q;
  assign if_ctr     = opcode_of(if_instr_q);
  assign if_funcode = funcode_of(if_instr_q);
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a 128-word instance and a 4-word instance,
// each driven from its own behavioural instruction memory.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_s;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;

  logic [31:0] imem_addr, imem_instr, if_instr, if_pc;
  logic [5:0]  if_ctr, if_funcode;
  logic        if_valid, halted, fault;
  logic [15:0] fetch_count;

  logic [31:0] imem_addr_s, imem_instr_s, if_instr_s, if_pc_s;
  logic [5:0]  if_ctr_s, if_funcode_s;
  logic        if_valid_s, halted_s, fault_s;
  logic [15:0] fetch_count_s;

  logic [31:0] mem   [128];
  logic [31:0] mem_s [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr   = (imem_addr < 32'd512) ? mem[imem_addr[8:2]] : 32'h0;
  assign imem_instr_s = (imem_addr_s < 32'd16) ? mem_s[imem_addr_s[3:2]] : 32'h0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ctr(if_ctr), .if_funcode(if_funcode),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  fetch_sequencer #(.SIZE_IM(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr_s), .imem_instr(imem_instr_s),
    .if_valid(if_valid_s), .if_instr(if_instr_s), .if_pc(if_pc_s),
    .if_ctr(if_ctr_s), .if_funcode(if_funcode_s),
    .halted(halted_s), .fault(fault_s), .fetch_count(fetch_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input int cnt);
    check({tag, "_valid"}, 32'(if_valid), 32'd1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_instr"}, if_instr, instr);
    check({tag, "_cnt"}, 32'(fetch_count), 32'(cnt));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0000;
    mem[0]  = 32'h2008_0005;
    mem[1]  = 32'h0109_5020;
    mem[2]  = 32'h0000_0000;
    mem[3]  = 32'hFC00_0000;
    mem[16] = 32'h1234_5678;
    mem[17] = 32'hFC00_0000;
    mem_s[0] = 32'h0000_0011;
    mem_s[1] = 32'h0000_0022;
    mem_s[2] = 32'h0000_0033;
    mem_s[3] = 32'h0000_0044;

    rst = 1'b1; start = 1'b0; start_s = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 32'h0;
    #12;
    rst = 1'b0;
    tick();

    check("rst_addr", imem_addr, 32'hFFFF_FFFC);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'hFC00_0000);
    check("rst_pc", if_pc, 32'hFFFF_FFFC);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_cnt", 32'(fetch_count), 32'd0);

    // Straight-line run up to the halt word.
    pulse_start();
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_valid0", 32'(if_valid), 32'd0);
    tick(); expect_fetch("t1_i0", 32'h0, 32'h2008_0005, 1);
    check("t1_ctr", 32'(if_ctr), 32'h08);
    check("t1_func", 32'(if_funcode), 32'h05);
    tick(); expect_fetch("t1_i1", 32'h4, 32'h0109_5020, 2);
    tick(); expect_fetch("t1_i2", 32'h8, 32'h0000_0000, 3);
    tick();
    check("t1_valid_halt", 32'(if_valid), 32'd0);
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_fault", 32'(fault), 32'd0);
    check("t1_cnt", 32'(fetch_count), 32'd3);

    // Two stalled cycles after the second instruction.
    pulse_start();
    tick(); expect_fetch("t2_i0", 32'h0, 32'h2008_0005, 1);
    tick(); expect_fetch("t2_i1", 32'h4, 32'h0109_5020, 2);
    stall = 1'b1;
    tick(); expect_fetch("t2_s0", 32'h4, 32'h0109_5020, 2);
    check("t2_s0_addr", imem_addr, 32'h8);
    tick(); expect_fetch("t2_s1", 32'h4, 32'h0109_5020, 2);
    stall = 1'b0;
    tick(); expect_fetch("t2_i2", 32'h8, 32'h0000_0000, 3);
    tick();
    check("t2_halted", 32'(halted), 32'd1);

    // Redirect together with stall at pc=8.
    pulse_start();
    tick(); tick();
    check("t3_addr8", imem_addr, 32'h8);
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0040; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    check("t3_flush", 32'(if_valid), 32'd0);
    check("t3_addr", imem_addr, 32'h40);
    check("t3_cnt_hold", 32'(fetch_count), 32'd2);
    tick(); expect_fetch("t3_tgt", 32'h40, 32'h1234_5678, 3);
    tick();
    check("t3_halted", 32'(halted), 32'd1);
    check("t3_fault", 32'(fault), 32'd0);

    // Misaligned redirect faults; restart clears fault and count.
    pulse_start();
    tick();
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0042;
    tick();
    redirect_valid = 1'b0;
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_valid", 32'(if_valid), 32'd0);
    pulse_start();
    check("t4_re_addr", imem_addr, 32'h0);
    check("t4_re_fault", 32'(fault), 32'd0);
    check("t4_re_cnt", 32'(fetch_count), 32'd0);
    check("t4_re_halted", 32'(halted), 32'd0);

    // Async reset mid-fetch at pc=8, applied between clock edges.
    tick(); tick();
    check("t6_addr8", imem_addr, 32'h8);
    #2 rst = 1'b1;
    #1;
    check("t6_addr", imem_addr, 32'hFFFF_FFFC);
    check("t6_valid", 32'(if_valid), 32'd0);
    check("t6_pc", if_pc, 32'hFFFF_FFFC);
    check("t6_instr", if_instr, 32'hFC00_0000);
    check("t6_cnt", 32'(fetch_count), 32'd0);
    #3 rst = 1'b0;
    tick();

    // SIZE_IM=4 instance with no halt word: range fault at pc=16.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5_pc%0d", i), if_pc_s, 32'(4 * i));
      check($sformatf("t5_v%0d", i), 32'(if_valid_s), 32'd1);
    end
    check("t5_instr3", if_instr_s, 32'h0000_0044);
    tick();
    check("t5_halted", 32'(halted_s), 32'd1);
    check("t5_fault", 32'(fault_s), 32'd1);
    check("t5_valid", 32'(if_valid_s), 32'd0);
    check("t5_cnt", 32'(fetch_count_s), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences the combinational instruction memory: drives its word address each cycle and registers the returned word into a fetch register for decode.
- Handles start, stall, branch/jump redirect, the all-ones-opcode halt marker, and out-of-range or misaligned faults.
- Sits between instruction memory and the decode/control stage of the CPU.

Parameters:
- SIZE_IM, 128, number of 32-bit words in instruction memory; legal PC range is 0 to 4*SIZE_IM-4.
- RESET_PC, 32'h0000_0000, first fetch address after start.
- HALT_OP, 6'b111111, opcode that terminates fetch.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins fetch from RESET_PC.
- stall  in  1  decode not ready; hold PC and fetch register.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_addr  in  32  target byte address.
- imem_addr  out  32  byte address to instruction memory (combinational from PC/state).
- imem_instr  in  32  word returned combinationally for imem_addr.
- if_valid  out  1  if_instr/if_pc hold a live instruction.
- if_instr  out  32  registered instruction.
- if_pc  out  32  address of if_instr.
- if_ctr  out  6  if_instr[31:26].
- if_funcode  out  6  if_instr[5:0].
- halted  out  1  sequencer in S_HALT.
- fault  out  1  halt caused by out-of-range PC or misaligned redirect.
- fetch_count  out  CNT_W  instructions delivered since start; saturates at all-ones.

Behaviour:
- Reset: state S_IDLE; pc=32'hFFFF_FFFC; if_valid=0; if_instr=32'hFC00_0000; if_pc=32'hFFFF_FFFC; halted=0; fault=0; fetch_count=0.
- imem_addr equals pc in every state. In S_IDLE this is 32'hFFFF_FFFC, the memory's init address.
- States:
  - S_IDLE: start -> S_FETCH, pc<=RESET_PC. Nothing else is accepted.
  - S_FETCH, no stall, no redirect: if_instr<=imem_instr, if_pc<=pc, pc<=pc+4 (32-bit wrap irrelevant; see range check).
    - If imem_instr[31:26]==HALT_OP: if_valid<=0, go to S_HALT, pc held, count unchanged. The halt word is never delivered.
    - Otherwise: if_valid<=1, fetch_count increments.
  - S_FETCH, stall=1 and no redirect: pc, if_valid, if_instr, if_pc and fetch_count all held. Halt is not detected while stalled.
  - S_FETCH, redirect_valid=1: pc<=redirect_addr, if_valid<=0 (flush). This has priority over stall and over halt detection in the same cycle.
    - If redirect_addr[1:0]!=0: go to S_HALT with fault<=1.
  - Range check: when pc >= 4*SIZE_IM in S_FETCH and there is no redirect, no capture occurs. Go to S_HALT with fault<=1 and if_valid<=0.
  - S_HALT: halted=1. redirect and stall are ignored. start -> S_FETCH with pc<=RESET_PC, fault<=0, fetch_count<=0, if_valid<=0.
- Latency: the instruction at pc appears on if_instr/if_valid one clock after the edge at which pc is presented. Sustained throughput is one instruction per cycle with stall=0.
- if_ctr and if_funcode are combinational slices of if_instr.
- Simultaneous events:
  - rst overrides everything.
  - start in S_FETCH is ignored.
  - In S_FETCH the priority order is redirect > range fault > stall > halt detect.
- Reset mid-operation: asynchronous return to the reset values above, regardless of stall or redirect.

Decomposition:
- Shared package/include holds:
  - state encodings S_IDLE=2'd0, S_FETCH=2'd1, S_HALT=2'd2;
  - HALT_WORD 32'hFC00_0000;
  - INIT_ADDR 32'hFFFF_FFFC.
  The instruction memory and decode use the same constants.
- One natural sub-module, sat_counter (CNT_W-bit saturating counter with clear and enable), used for fetch_count. Everything else stays flat.

Test Plan:
- Reset then start, memory words 0..3 = 32'h2008_0005, 32'h0109_5020, 32'h0000_0000, 32'hFC00_0000, stall=0 -> if_valid high for 3 cycles with if_pc 0,4,8. Then halted=1, fault=0, fetch_count=3, and if_valid never shows the halt word.
- Stall high for 2 cycles after the second instruction -> if_pc=4 and if_instr held for the 2 stalled cycles, fetch_count frozen, and fetch resumes at pc=8.
- Redirect: redirect_valid with redirect_addr=32'h0000_0040 asserted together with stall=1 at pc=8 -> next cycle if_valid=0 and imem_addr=32'h40; next delivered instruction has if_pc=32'h40.
- Misaligned redirect_addr=32'h0000_0042 -> next cycle halted=1, fault=1, if_valid=0. A later start restarts at pc=0 with fault=0 and fetch_count=0.
- Memory with no halt word, SIZE_IM=4 -> 4 instructions delivered (if_pc 0..12), then at pc=16 halted=1, fault=1, fetch_count=4.
- Assert rst asynchronously mid-fetch at pc=8 -> outputs immediately return to reset values (imem_addr=32'hFFFF_FFFC, if_valid=0) without waiting for a clock edge.
